// File: rtl/arb_rr_12.sv
// 12-way round-robin arbiter with grant hold until done/abort.
// Optional hold timeout enabled by defining ARB_TIMEOUT_EN (limit set by TIMEOUT).
module arb_rr_12 #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [11:0] req,
    input  logic        done,
    output logic [11:0] gnt,
    output logic [3:0]  gnt_idx,
    output logic        gnt_vld,
    output logic        to_err
);
    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    logic [3:0] ptr;
    logic [3:0] base;
    logic [3:0] win;
    logic       found;
    logic       hold_rel;
    logic       tmo;
    logic       release_now;
    logic       grant_now;

    // Scan starts just after base and wraps, so base itself is lowest priority.
    // While busy, base is the holder, which becomes ptr at a release edge.
    always_comb begin
        base  = (state == BUSY) ? gnt_idx : ptr;
        found = 1'b0;
        win   = 4'd0;
        for (int k = 1; k <= 12; k++) begin
            logic [4:0] s;
            s = {1'b0, base} + 5'(k);
            if (s >= 5'd12) s = s - 5'd12;
            if (!found && s < 5'd12 && req[s[3:0]]) begin
                found = 1'b1;
                win   = s[3:0];
            end
        end
    end

    assign hold_rel    = done || !req[gnt_idx];
    assign release_now = (state == BUSY) && (hold_rel || tmo);
    assign grant_now   = en && found && ((state == IDLE) || release_now);

`ifdef ARB_TIMEOUT_EN
    logic [7:0] cnt;

    assign tmo = (state == BUSY) && (cnt == TO_LAST);

    always_ff @(posedge clk) begin
        if (rst || grant_now)
            cnt <= 8'd0;
        else if (state == BUSY)
            cnt <= cnt + 8'd1;
    end
`else
    logic [7:0] unused_to_last;

    assign unused_to_last = TO_LAST;
    assign tmo            = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            gnt     <= 12'd0;
            gnt_idx <= 4'd0;
            gnt_vld <= 1'b0;
            to_err  <= 1'b0;
            ptr     <= 4'd11;
        end else begin
            // A timeout that coincides with done or abort is an ordinary release.
            to_err <= release_now && tmo && !hold_rel;
            if (release_now)
                ptr <= gnt_idx;
            if (grant_now) begin
                state   <= BUSY;
                gnt     <= 12'd1 << win;
                gnt_idx <= win;
                gnt_vld <= 1'b1;
            end else if (release_now) begin
                state   <= IDLE;
                gnt     <= 12'd0;
                gnt_idx <= 4'd0;
                gnt_vld <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_arb_rr_12.sv
// Bench for arb_rr_12: directed vectors, a per-cycle reference model and literal checks.
// Expectations for the timeout scenario follow ARB_TIMEOUT_EN.
module tb_arb_rr_12;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst, en, done;
    logic [11:0] req;
    logic [11:0] gnt;
    logic [3:0]  gnt_idx;
    logic        gnt_vld, to_err;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    arb_rr_12 #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .en(en), .req(req), .done(done),
        .gnt(gnt), .gnt_idx(gnt_idx), .gnt_vld(gnt_vld), .to_err(to_err)
    );

    always #5 clk = ~clk;

    // Reference model: what the outputs must be after each edge.
    bit       m_vld, m_err;
    int       m_idx, m_ptr, m_cnt;
    bit       tmo_en;

    initial begin
`ifdef ARB_TIMEOUT_EN
        tmo_en = 1'b1;
`else
        tmo_en = 1'b0;
`endif
    end

    always @(posedge clk) begin
        bit rel, pick;
        if (rst) begin
            m_vld = 0; m_idx = 0; m_ptr = 11; m_cnt = 0; m_err = 0;
        end else begin
            rel = 0;
            m_err = 0;
            if (m_vld) begin
                if (done || !req[m_idx]) rel = 1;
                else if (tmo_en && m_cnt == TIMEOUT - 1) begin rel = 1; m_err = 1; end
                if (rel) m_ptr = m_idx;
                else m_cnt++;
            end
            if (!m_vld || rel) begin
                pick = 0;
                if (en) begin
                    for (int k = 1; k <= 12; k++) begin
                        if (!pick && req[(m_ptr + k) % 12]) begin
                            pick = 1; m_idx = (m_ptr + k) % 12;
                        end
                    end
                end
                if (pick) begin m_vld = 1; m_cnt = 0; end
                else begin m_vld = 0; m_idx = 0; end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            logic [11:0] eg;
            eg = m_vld ? (12'd1 << m_idx) : 12'd0;
            n_cmp++;
            if (gnt !== eg || gnt_idx !== 4'(m_idx) || gnt_vld !== m_vld || to_err !== m_err) begin
                n_bad++;
                $display("FAIL model t=%0t got gnt=%h idx=%0d vld=%b err=%b, want gnt=%h idx=%0d vld=%b err=%b",
                         $time, gnt, gnt_idx, gnt_vld, to_err, eg, m_idx, m_vld, m_err);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_done;
        done = 1'b1; step(); done = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; req = 12'h000; done = 1'b0;
        @(posedge clk);
        chk_on = 1'b1;
        step(2);
        chk("reset_vld", gnt_vld, 0);
        chk("reset_gnt", gnt, 0);

        // first grant one cycle after request
        rst = 1'b0; en = 1'b1; req = 12'h001;
        step();
        chk("first_gnt", gnt, 12'h001);
        chk("first_idx", gnt_idx, 0);

        // full rotation with done every third cycle
        req = 12'hFFF;
        for (int k = 1; k <= 12; k++) begin
            step(2);
            pulse_done();
            chk($sformatf("rot_%0d", k), gnt_idx, k % 12);
        end
        chk("rot_vld", gnt_vld, 1);

        // holder 5, then 9, then 2
        req = 12'h020; step();
        chk("h5", gnt_idx, 5);
        req = 12'h224; step();
        pulse_done();
        chk("after5", gnt_idx, 9);
        step();
        pulse_done();
        chk("after9", gnt_idx, 2);

        // abort without done
        req = 12'h008; step();
        chk("h3", gnt_idx, 3);
        req = 12'h080; step();
        chk("abort3", gnt_idx, 7);

        // en low blocks re-grant after done
        req = 12'h010; step();
        chk("h4", gnt_idx, 4);
        en = 1'b0; req = 12'h012; step();
        chk("hold_en0", gnt_idx, 4);
        pulse_done();
        chk("en0_rel", gnt_vld, 0);
        step(3);
        chk("en0_stay", gnt_vld, 0);
        en = 1'b1; step();
        chk("en1_idx", gnt_idx, 1);

        // done while idle is ignored
        req = 12'h000; step();
        chk("idle_vld", gnt_vld, 0);
        pulse_done();
        chk("idle_done", gnt_vld, 0);

        // hold timeout
        req = 12'h040; step();
        chk("h6", gnt_idx, 6);
        req = 12'h140; step(15);
        chk("h6_15", gnt_idx, 6);
        step();
        if (tmo_en) begin
            chk("to_idx", gnt_idx, 8);
            chk("to_err", to_err, 1);
            step();
            chk("to_err_pulse", to_err, 0);
        end else begin
            chk("noto_idx", gnt_idx, 6);
            chk("noto_err", to_err, 0);
        end

        // reset mid-grant
        rst = 1'b1; step();
        chk("rst_vld", gnt_vld, 0);
        chk("rst_err", to_err, 0);
        rst = 1'b0; req = 12'hFFF; step();
        chk("post_rst", gnt_idx, 0);

        // done and abort together
        req = 12'hFFE; done = 1'b1; step(); done = 1'b0;
        chk("done_abort", gnt_idx, 1);
        step(2);

        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
